scalar_mult_25519: RTL and testbench
====================================

# scalar_mult_25519

Constant-time scalar-multiplication sequencer for Ed25519: computes Q = k·P on extended twisted-Edwards coordinates (X:Y:Z:T) by MSB-first double-and-always-add. It sits directly upstream of the point add/double unit `point_op_25519`, which it drives over a start/done handshake. Its result feeds affine conversion and encoding.

## Interface
- NBITS, 255: scalar width; number of loop iterations.
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- scalar  in  NBITS  k; sampled in the start cycle
- base_x, base_y, base_z, base_t  in  255 each  P; sampled in the start cycle
- res_x, res_y, res_z, res_t  out  255 each  Q; valid from the done pulse until the next start
- done  out  1  one-cycle pulse; result valid
- busy  out  1  high whenever state ≠ IDLE
- po_start  out  1  start to the point unit
- po_mode  out  2  00 = ADD, 01 = DBL
- po_p1_x/y/z/t, po_p2_x/y/z/t  out  255 each  point-unit operands
- po_res_x/y/z/t  in  255 each  point-unit result; valid when po_done is high
- po_done, po_busy  in  1 each  point-unit status

## Operation
- The point unit re-reads its operand inputs throughout an operation. po_mode, po_p1_* and po_p2_* must therefore be driven from registers and held constant from the po_start cycle through the po_done cycle.

**Registers**
- R: accumulator, four coordinates.
- P: latched base point.
- K: NBITS-bit shift register holding the scalar.
- cnt: ⌈log2 NBITS⌉-bit iteration counter.

**States**
- IDLE: on start, go to LOAD; otherwise hold.
- LOAD:
  - P ← base; K ← scalar; R ← identity (0,1,1,0); cnt ← NBITS−1.
  - Go to DBL_ISSUE.
- DBL_ISSUE:
  - Drive po_mode = 01 and p1 = p2 = R.
  - Once po_busy = 0, assert po_start for exactly one cycle, then go to DBL_WAIT.
- DBL_WAIT: on po_done, R ← po_res and go to ADD_ISSUE.
- ADD_ISSUE:
  - Drive po_mode = 00, p1 = R, p2 = P.
  - Assert po_start under the same rule as DBL_ISSUE, then go to ADD_WAIT.
- ADD_WAIT:
  - On po_done, if K[NBITS−1] = 1 then R ← po_res; otherwise discard the result.
  - Go to NEXT.
- NEXT:
  - K ← K << 1.
  - If cnt = 0, go to FINISH; otherwise cnt ← cnt−1 and go to DBL_ISSUE.
- FINISH: res_* ← R, done = 1, go to IDLE.

**Behavioural rules**
- The add is always issued, regardless of the bit value. The choice between keeping and discarding its result is a register-enable mux only.
- Control flow and cycle count are independent of k. There is no leading-zero skip and no early exit.
- start while busy is ignored, with no effect on the run in progress.
- Outputs are projective and are not normalised. Scalar reduction mod L and clamping are the caller's job.
- po_done outside a WAIT state is ignored.

## Timing
- Reset values:
  - State IDLE.
  - done, busy, po_start: 0; po_mode: 00.
  - res_*, po_p1_*, po_p2_*: all zero.
- Reset mid-operation: the block returns to IDLE immediately and no done pulse is produced. The point unit shares rst, so it aborts too.
- start sampled in cycle 0 → LOAD in cycle 1 → busy high from cycle 1.
- Let D be the number of cycles from the po_start cycle to the po_done cycle, inclusive of the latter.
  - Per iteration: 2·(1 + D) + 1 cycles, assuming po_busy is already 0 at each ISSUE.
  - done is high in cycle 1 + NBITS·(2D+3) + 1, measured from the start cycle.
  - busy falls in the cycle after done.
- po_start is never high on two consecutive cycles. It is never asserted while po_busy = 1.
- A new start is accepted in the cycle after done (IDLE).

## Test plan
- Stub point unit with NBITS = 4, D = 3, performing real field arithmetic:
  - scalar = 0 → done at cycle 38; result X = 0 and Y = Z ≠ 0.
  - scalar = 4'hF → done at the same cycle 38 (constant time).
  - Exactly 8 po_start pulses, alternating mode 01/00.
- Real point unit with NBITS = 255 and P = Ed25519 base point B:
  - k = 1 → X·Zb = Xb·Z and Y·Zb = Yb·Z.
  - k = 2 → projectively equal to B+B.
  - k = 8 → projectively equal to the reference value of 8B.
- k = group order L (0x1000…14DEF9DEA2F79CD65812631A5CF5D3ED) with P = B → identity (X = 0, Y = Z).
- Operand stability: assert that po_mode, po_p1_* and po_p2_* do not change between po_start and po_done across a full run.
- start re-pulsed at cycle 10 of a run → ignored; result and done cycle unchanged. start in the cycle after done → second run proceeds correctly.
- rst low in the middle of ADD_WAIT → busy = 0 and all outputs zero that cycle, no done pulse. A new start after rst goes high gives the correct result for k = 1.

Source files
------------

// File: rtl/scalar_mult_25519.sv
// Constant-time Ed25519 scalar multiplier: MSB-first double-and-always-add
// over extended coordinates, sequencing an external point add/double unit.
module scalar_mult_25519 #(
  parameter int NBITS = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] scalar,
  input  logic [254:0]     base_x,
  input  logic [254:0]     base_y,
  input  logic [254:0]     base_z,
  input  logic [254:0]     base_t,
  output logic [254:0]     res_x,
  output logic [254:0]     res_y,
  output logic [254:0]     res_z,
  output logic [254:0]     res_t,
  output logic             done,
  output logic             busy,
  output logic             po_start,
  output logic [1:0]       po_mode,
  output logic [254:0]     po_p1_x,
  output logic [254:0]     po_p1_y,
  output logic [254:0]     po_p1_z,
  output logic [254:0]     po_p1_t,
  output logic [254:0]     po_p2_x,
  output logic [254:0]     po_p2_y,
  output logic [254:0]     po_p2_z,
  output logic [254:0]     po_p2_t,
  input  logic [254:0]     po_res_x,
  input  logic [254:0]     po_res_y,
  input  logic [254:0]     po_res_z,
  input  logic [254:0]     po_res_t,
  input  logic             po_done,
  input  logic             po_busy
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_DBL = 2'b01;

  typedef struct packed {
    logic [254:0] x;
    logic [254:0] y;
    logic [254:0] z;
    logic [254:0] t;
  } pt_t;

  localparam pt_t IDENT = pt_t'({255'd0, 255'd1, 255'd1, 255'd0});

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DBL_ISSUE,
    DBL_WAIT,
    ADD_ISSUE,
    ADD_WAIT,
    NEXT,
    FINISH
  } state_t;

  state_t state, nxt;

  pt_t r, p, p2, res, po_res;
  logic [NBITS-1:0] k;
  logic [CW-1:0]    cnt;
  logic [1:0]       mode;

  assign po_res = pt_t'({po_res_x, po_res_y, po_res_z, po_res_t});

  // p1 is always the accumulator, which only moves after a po_done
  assign {po_p1_x, po_p1_y, po_p1_z, po_p1_t} = r;
  assign {po_p2_x, po_p2_y, po_p2_z, po_p2_t} = p2;
  assign {res_x, res_y, res_z, res_t} = res;
  assign po_mode = mode;

  assign done = (state == FINISH);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt      = state;
    po_start = 1'b0;
    unique case (state)
      IDLE:      if (start) nxt = LOAD;
      LOAD:      nxt = DBL_ISSUE;
      DBL_ISSUE: if (!po_busy) begin
        po_start = 1'b1;
        nxt      = DBL_WAIT;
      end
      DBL_WAIT:  if (po_done) nxt = ADD_ISSUE;
      ADD_ISSUE: if (!po_busy) begin
        po_start = 1'b1;
        nxt      = ADD_WAIT;
      end
      ADD_WAIT:  if (po_done) nxt = NEXT;
      NEXT:      nxt = (cnt == '0) ? FINISH : DBL_ISSUE;
      FINISH:    nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // operands for the next op are staged as the previous one completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r    <= '0;
      p    <= '0;
      p2   <= '0;
      res  <= '0;
      k    <= '0;
      cnt  <= '0;
      mode <= MODE_ADD;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          p <= pt_t'({base_x, base_y, base_z, base_t});
          k <= scalar;
        end
        LOAD: begin
          r    <= IDENT;
          p2   <= IDENT;
          mode <= MODE_DBL;
          cnt  <= CW'(NBITS - 1);
        end
        DBL_WAIT: if (po_done) begin
          r    <= po_res;
          p2   <= p;
          mode <= MODE_ADD;
        end
        ADD_WAIT: if (po_done && k[NBITS-1]) r <= po_res;
        NEXT: begin
          k <= k << 1;
          if (cnt != '0) begin
            cnt  <= cnt - CW'(1);
            p2   <= r;
            mode <= MODE_DBL;
          end else begin
            res <= r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_mult_25519.sv
// Bench for scalar_mult_25519: two instances (NBITS 4 and 255) driving
// behavioural point units that do real GF(2^255-19) Edwards arithmetic.
module tb_scalar_mult_25519;

  localparam int D = 3;
  localparam logic [255:0] PM = (256'd1 << 255) - 256'd19;
  localparam logic [255:0] BX =
    256'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
  localparam logic [255:0] BY =
    256'h6666666666666666666666666666666666666666666666666666666666666658;
  localparam logic [255:0] LORD =
    256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

  typedef struct packed {
    logic [254:0] x;
    logic [254:0] y;
    logic [254:0] z;
    logic [254:0] t;
  } pt_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  pt_t          gb;
  logic [254:0] gd2;
  logic [254:0] bx, by, bz, bt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [254:0] fadd(input logic [254:0] a, input logic [254:0] b);
    logic [255:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= PM) s = s - PM;
    return s[254:0];
  endfunction

  function automatic logic [254:0] fsub(input logic [254:0] a, input logic [254:0] b);
    logic [255:0] s;
    s = (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + PM - {1'b0, b};
    return s[254:0];
  endfunction

  function automatic logic [254:0] fmul(input logic [254:0] a, input logic [254:0] b);
    logic [509:0] m;
    m = {255'd0, a} * {255'd0, b};
    m = m % {254'd0, PM};
    return m[254:0];
  endfunction

  function automatic logic [254:0] finv(input logic [254:0] a);
    logic [255:0] e;
    logic [254:0] r;
    e = PM - 256'd2;
    r = 255'd1;
    for (int i = 254; i >= 0; i--) begin
      r = fmul(r, r);
      if (e[i]) r = fmul(r, a);
    end
    return r;
  endfunction

  // unified (complete) extended-coordinate addition, a = -1
  function automatic pt_t pt_add(input pt_t p, input pt_t q);
    logic [254:0] a, b, c, dd, e, f, g, h;
    pt_t r;
    a  = fmul(fsub(p.y, p.x), fsub(q.y, q.x));
    b  = fmul(fadd(p.y, p.x), fadd(q.y, q.x));
    c  = fmul(fmul(p.t, gd2), q.t);
    dd = fmul(fadd(p.z, p.z), q.z);
    e  = fsub(b, a);
    f  = fsub(dd, c);
    g  = fadd(dd, c);
    h  = fadd(b, a);
    r.x = fmul(e, f);
    r.y = fmul(g, h);
    r.t = fmul(e, h);
    r.z = fmul(f, g);
    return r;
  endfunction

  function automatic pt_t pt_op(input logic [1:0] m, input pt_t p, input pt_t q);
    if (m == 2'b00 || m == 2'b01) return pt_add(p, q);
    return '0;
  endfunction

  function automatic pt_t ref_mul(input logic [254:0] k, input int nb, input pt_t p);
    pt_t r;
    r = pt_t'({255'd0, 255'd1, 255'd1, 255'd0});
    for (int i = nb - 1; i >= 0; i--) begin
      r = pt_add(r, r);
      if (k[i]) r = pt_add(r, p);
    end
    return r;
  endfunction

  function automatic logic proj_eq(input pt_t a, input pt_t b);
    return (a.z != 0) &&
           (fmul(a.x, b.z) == fmul(b.x, a.z)) &&
           (fmul(a.y, b.z) == fmul(b.y, a.z));
  endfunction

  // instance A: NBITS = 4
  logic         a_start, a_done, a_busy, a_ps, a_pd, a_pb;
  logic [3:0]   a_scalar;
  logic [1:0]   a_pm;
  logic [254:0] a_rx, a_ry, a_rz, a_rt;
  logic [254:0] a_1x, a_1y, a_1z, a_1t, a_2x, a_2y, a_2z, a_2t;
  logic [254:0] a_sx, a_sy, a_sz, a_st;

  scalar_mult_25519 #(.NBITS(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .scalar(a_scalar),
    .base_x(bx), .base_y(by), .base_z(bz), .base_t(bt),
    .res_x(a_rx), .res_y(a_ry), .res_z(a_rz), .res_t(a_rt),
    .done(a_done), .busy(a_busy), .po_start(a_ps), .po_mode(a_pm),
    .po_p1_x(a_1x), .po_p1_y(a_1y), .po_p1_z(a_1z), .po_p1_t(a_1t),
    .po_p2_x(a_2x), .po_p2_y(a_2y), .po_p2_z(a_2z), .po_p2_t(a_2t),
    .po_res_x(a_sx), .po_res_y(a_sy), .po_res_z(a_sz), .po_res_t(a_st),
    .po_done(a_pd), .po_busy(a_pb)
  );

  // instance B: NBITS = 255
  logic         b_start, b_done, b_busy, b_ps, b_pd, b_pb;
  logic [254:0] b_scalar;
  logic [1:0]   b_pm;
  logic [254:0] b_rx, b_ry, b_rz, b_rt;
  logic [254:0] b_1x, b_1y, b_1z, b_1t, b_2x, b_2y, b_2z, b_2t;
  logic [254:0] b_sx, b_sy, b_sz, b_st;

  scalar_mult_25519 #(.NBITS(255)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .scalar(b_scalar),
    .base_x(bx), .base_y(by), .base_z(bz), .base_t(bt),
    .res_x(b_rx), .res_y(b_ry), .res_z(b_rz), .res_t(b_rt),
    .done(b_done), .busy(b_busy), .po_start(b_ps), .po_mode(b_pm),
    .po_p1_x(b_1x), .po_p1_y(b_1y), .po_p1_z(b_1z), .po_p1_t(b_1t),
    .po_p2_x(b_2x), .po_p2_y(b_2y), .po_p2_z(b_2z), .po_p2_t(b_2t),
    .po_res_x(b_sx), .po_res_y(b_sy), .po_res_z(b_sz), .po_res_t(b_st),
    .po_done(b_pd), .po_busy(b_pb)
  );

  // point-unit stubs: po_done arrives D cycles after po_start
  logic [2:0] a_cnt, b_cnt;
  pt_t        a_q, b_q;

  always @(posedge clk or negedge rst) begin
    if (!rst) a_cnt <= '0;
    else begin
      if (a_cnt != 0) a_cnt <= (a_cnt == 3'(D)) ? 3'd0 : a_cnt + 3'd1;
      else if (a_ps)  a_cnt <= 3'd1;
      if (a_cnt == 3'(D - 1))
        a_q <= pt_op(a_pm, pt_t'({a_1x, a_1y, a_1z, a_1t}),
                     pt_t'({a_2x, a_2y, a_2z, a_2t}));
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) b_cnt <= '0;
    else begin
      if (b_cnt != 0) b_cnt <= (b_cnt == 3'(D)) ? 3'd0 : b_cnt + 3'd1;
      else if (b_ps)  b_cnt <= 3'd1;
      if (b_cnt == 3'(D - 1))
        b_q <= pt_op(b_pm, pt_t'({b_1x, b_1y, b_1z, b_1t}),
                     pt_t'({b_2x, b_2y, b_2z, b_2t}));
    end
  end

  assign a_pd = (a_cnt == 3'(D));
  assign a_pb = (a_cnt != 0);
  assign {a_sx, a_sy, a_sz, a_st} = a_q;
  assign b_pd = (b_cnt == 3'(D));
  assign b_pb = (b_cnt != 0);
  assign {b_sx, b_sy, b_sz, b_st} = b_q;

  // handshake and operand-stability monitors
  logic [2039:0] a_snap, b_snap;
  logic [1:0]    a_msnap, b_msnap;
  logic          a_prev = 1'b0, b_prev = 1'b0;
  int            a_unst = 0, b_unst = 0, a_bad = 0, b_bad = 0;
  int            a_nps = 0, a_ndone = 0;
  logic [1:0]    a_modes [256];

  always @(posedge clk) begin
    a_prev <= a_ps;
    b_prev <= b_ps;
    if (a_ps && (a_prev || a_pb)) a_bad <= a_bad + 1;
    if (b_ps && (b_prev || b_pb)) b_bad <= b_bad + 1;
    if (a_ps) begin
      a_snap  <= {a_1x, a_1y, a_1z, a_1t, a_2x, a_2y, a_2z, a_2t};
      a_msnap <= a_pm;
      a_modes[a_nps % 256] <= a_pm;
      a_nps <= a_nps + 1;
    end
    if (b_ps) begin
      b_snap  <= {b_1x, b_1y, b_1z, b_1t, b_2x, b_2y, b_2z, b_2t};
      b_msnap <= b_pm;
    end
    if (a_done) a_ndone <= a_ndone + 1;
  end

  always @(negedge clk) begin
    if (a_pb && ({a_pm, a_1x, a_1y, a_1z, a_1t, a_2x, a_2y, a_2z, a_2t}
                 !== {a_msnap, a_snap})) a_unst <= a_unst + 1;
    if (b_pb && ({b_pm, b_1x, b_1y, b_1z, b_1t, b_2x, b_2y, b_2z, b_2t}
                 !== {b_msnap, b_snap})) b_unst <= b_unst + 1;
  end

  // entered and left at a negedge; returns at the negedge of the done cycle
  task automatic run(input int which, input logic [254:0] k, input int repulse,
                     output int dcyc, output pt_t r);
    int t0;
    if (which == 0) begin a_scalar = k[3:0]; a_start = 1'b1; end
    else begin b_scalar = k; b_start = 1'b1; end
    t0 = cyc;
    dcyc = -1;
    r = '0;
    @(negedge clk);
    for (int i = 0; i < 4000 && dcyc < 0; i++) begin
      a_start = (which == 0) && (repulse != 0) && (cyc - t0 == repulse);
      b_start = (which != 0) && (repulse != 0) && (cyc - t0 == repulse);
      if (a_start) a_scalar = ~a_scalar;
      if (b_start) b_scalar = ~b_scalar;
      if (which == 0 ? a_done : b_done) begin
        dcyc = cyc - t0;
        r = (which == 0) ? pt_t'({a_rx, a_ry, a_rz, a_rt})
                         : pt_t'({b_rx, b_ry, b_rz, b_rt});
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_ps, a_pm} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl_a got busy=%b done=%b po_start=%b mode=%b want 0",
               a_busy, a_done, a_ps, a_pm);
    end
    checks++;
    if ({a_rx, a_ry, a_rz, a_rt, a_1x, a_1y, a_1z, a_1t,
         a_2x, a_2y, a_2z, a_2t} !== '0) begin
      errors++;
      $display("FAIL reset_data_a got res_y=%h p1_y=%h want 0", a_ry, a_1y);
    end
    checks++;
    if ({b_busy, b_done, b_ps, b_pm} !== 5'b0 ||
        {b_rx, b_ry, b_rz, b_rt, b_1x, b_1y, b_1z, b_1t,
         b_2x, b_2y, b_2z, b_2t} !== '0) begin
      errors++;
      $display("FAIL reset_b got busy=%b done=%b res_y=%h want 0", b_busy, b_done, b_ry);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_const_time;
    int  dc, n0;
    pt_t r, e;
    n0 = a_nps;
    run(0, 255'd0, 0, dc, r);
    checks++;
    if (dc !== 38) begin
      errors++;
      $display("FAIL k0_done_cycle got %0d want 38", dc);
    end
    checks++;
    if (r.x !== 255'd0 || r.y !== r.z || r.y === 255'd0) begin
      errors++;
      $display("FAIL k0_identity got x=%h y=%h z=%h want x=0 y=z!=0", r.x, r.y, r.z);
    end
    checks++;
    if (a_nps - n0 !== 8) begin
      errors++;
      $display("FAIL k0_pulses got %0d want 8", a_nps - n0);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (a_modes[(n0 + i) % 256] !== ((i % 2 == 0) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL mode_seq[%0d] got %b want %b", i, a_modes[(n0 + i) % 256],
                 (i % 2 == 0) ? 2'b01 : 2'b00);
      end
    end
    @(negedge clk);
    n0 = a_nps;
    run(0, 255'hf, 0, dc, r);
    e = ref_mul(255'hf, 4, gb);
    checks++;
    if (dc !== 38) begin
      errors++;
      $display("FAIL kf_done_cycle got %0d want 38", dc);
    end
    checks++;
    if (proj_eq(r, e) !== 1'b1) begin
      errors++;
      $display("FAIL kf_result got x=%h z=%h want x=%h z=%h", r.x, r.z, e.x, e.z);
    end
    checks++;
    if (a_nps - n0 !== 8) begin
      errors++;
      $display("FAIL kf_pulses got %0d want 8", a_nps - n0);
    end
    @(negedge clk);
  endtask

  task automatic test_full_width;
    int  dc;
    pt_t r, e;
    run(1, 255'd1, 0, dc, r);
    checks++;
    if (dc !== 2297) begin
      errors++;
      $display("FAIL k1_done_cycle got %0d want 2297", dc);
    end
    checks++;
    if (proj_eq(r, gb) !== 1'b1) begin
      errors++;
      $display("FAIL k1_result got x=%h y=%h z=%h", r.x, r.y, r.z);
    end
    @(negedge clk);
    run(1, 255'd2, 0, dc, r);
    e = pt_add(gb, gb);
    checks++;
    if (proj_eq(r, e) !== 1'b1) begin
      errors++;
      $display("FAIL k2_result got x=%h z=%h want x=%h z=%h", r.x, r.z, e.x, e.z);
    end
    @(negedge clk);
    run(1, 255'd8, 0, dc, r);
    e = pt_add(gb, gb);
    e = pt_add(e, e);
    e = pt_add(e, e);
    checks++;
    if (proj_eq(r, e) !== 1'b1) begin
      errors++;
      $display("FAIL k8_result got x=%h z=%h want x=%h z=%h", r.x, r.z, e.x, e.z);
    end
    @(negedge clk);
    run(1, LORD[254:0], 0, dc, r);
    checks++;
    if (r.x !== 255'd0 || r.y !== r.z || r.y === 255'd0) begin
      errors++;
      $display("FAIL kL_identity got x=%h y=%h z=%h want x=0 y=z", r.x, r.y, r.z);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int  dc;
    pt_t r, e;
    run(0, 255'd5, 10, dc, r);
    e = ref_mul(255'd5, 4, gb);
    checks++;
    if (dc !== 38 || proj_eq(r, e) !== 1'b1) begin
      errors++;
      $display("FAIL repulse got cycle=%0d x=%h want cycle=38 x~%h", dc, r.x, e.x);
    end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done got %b want 0", a_busy);
    end
    run(0, 255'd3, 0, dc, r);
    e = ref_mul(255'd3, 4, gb);
    checks++;
    if (dc !== 38 || proj_eq(r, e) !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back got cycle=%0d x=%h want cycle=38 x~%h", dc, r.x, e.x);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int  dc, nd, i;
    pt_t r;
    a_scalar = 4'd1;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    i = 0;
    while (!(a_busy && a_pb && a_pm == 2'b00) && i < 100) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (i >= 100) begin
      errors++;
      $display("FAIL reach_add_wait got timeout want ADD_WAIT");
    end
    nd = a_ndone;
    rst = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_done, a_ps, a_pm} !== 5'b0 ||
        {a_rx, a_ry, a_rz, a_rt, a_1x, a_1y, a_1z, a_1t,
         a_2x, a_2y, a_2z, a_2t} !== '0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b done=%b mode=%b p1_y=%h want 0",
               a_busy, a_done, a_pm, a_1y);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (a_ndone !== nd) begin
      errors++;
      $display("FAIL no_done_on_reset got %0d pulses want 0", a_ndone - nd);
    end
    run(0, 255'd1, 0, dc, r);
    checks++;
    if (dc !== 38 || proj_eq(r, gb) !== 1'b1) begin
      errors++;
      $display("FAIL after_reset got cycle=%0d x=%h want cycle=38 x~%h", dc, r.x, gb.x);
    end
    @(negedge clk);
  endtask

  task automatic test_handshake;
    checks++;
    if (a_unst !== 0 || b_unst !== 0) begin
      errors++;
      $display("FAIL operand_stability got a=%0d b=%0d changes want 0", a_unst, b_unst);
    end
    checks++;
    if (a_bad !== 0 || b_bad !== 0) begin
      errors++;
      $display("FAIL po_start_rule got a=%0d b=%0d want 0", a_bad, b_bad);
    end
  endtask

  initial begin
    logic [254:0] d;
    a_start = 1'b0;
    b_start = 1'b0;
    a_scalar = '0;
    b_scalar = '0;
    d = fmul(PM[254:0] - 255'd121665, finv(255'd121666));
    gd2 = fadd(d, d);
    gb.x = BX[254:0];
    gb.y = BY[254:0];
    gb.z = 255'd1;
    gb.t = fmul(gb.x, gb.y);
    {bx, by, bz, bt} = gb;
    test_reset;
    test_const_time;
    test_full_width;
    test_back_to_back;
    test_reset_mid;
    test_handshake;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
